// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage of the five-stage pipeline plus the 32 x 32-bit
// architectural register file. Selects load or ALU data, aligns and extends
// sub-word loads, commits to the register file, serves two combinational read
// ports with same-cycle write-through bypass and counts retired instructions.
module wb_regfile #(
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic             wb_is_load,
    input  logic [1:0]       wb_size,
    input  logic             wb_unsigned,
    input  logic [1:0]       wb_addr_lo,
    input  logic [31:0]      mem_data_in,
    input  logic [31:0]      data_in,
    input  logic [4:0]       rgD_index_in,
    input  logic [4:0]       rdA_index,
    input  logic [4:0]       rdB_index,
    output logic [31:0]      rdA_data,
    output logic [31:0]      rdB_data,
    output logic [31:0]      wb_data_out,
    output logic             wb_we_out,
    output logic [CNT_W-1:0] retired_count
);

    // Architectural state. Entry 0 exists only so indexing stays simple;
    // it is never written and reads are forced to zero.
    logic [31:0]      r_regs [0:NREGS-1];
    logic [CNT_W-1:0] r_retired;

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_wb_data;
    logic             w_we;

    // Bubbles and writes aimed at r0 never reach the register file or bypass.
    assign w_we = wb_valid & wb_reg_write & (rgD_index_in != 5'd0);

    // Load alignment/extension and writeback value selection.
    always_comb begin
        w_byte    = 8'd0;
        w_half    = 16'd0;
        w_load    = 32'd0;
        w_wb_data = 32'd0;

        case (wb_addr_lo)
            2'd0:    w_byte = mem_data_in[7:0];
            2'd1:    w_byte = mem_data_in[15:8];
            2'd2:    w_byte = mem_data_in[23:16];
            2'd3:    w_byte = mem_data_in[31:24];
            default: w_byte = mem_data_in[7:0];
        endcase

        // Bit 0 of the address is dropped: misaligned halves align down.
        if (wb_addr_lo[1]) begin
            w_half = mem_data_in[31:16];
        end else begin
            w_half = mem_data_in[15:0];
        end

        case (wb_size)
            2'b00:   w_load = {{24{w_byte[7] & ~wb_unsigned}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~wb_unsigned}}, w_half};
            default: w_load = mem_data_in;
        endcase

        if (wb_is_load) begin
            w_wb_data = w_load;
        end else begin
            w_wb_data = data_in;
        end
    end

    assign wb_data_out = w_wb_data;
    assign wb_we_out   = w_we;

    // Read port A: r0 is zero, a matching in-flight write bypasses storage.
    always_comb begin
        rdA_data = 32'd0;
        if (rdA_index == 5'd0) begin
            rdA_data = 32'd0;
        end else if (w_we && (rdA_index == rgD_index_in)) begin
            rdA_data = w_wb_data;
        end else if (int'(rdA_index) < NREGS) begin
            rdA_data = r_regs[rdA_index];
        end else begin
            rdA_data = 32'd0;
        end
    end

    // Read port B: same rule as port A.
    always_comb begin
        rdB_data = 32'd0;
        if (rdB_index == 5'd0) begin
            rdB_data = 32'd0;
        end else if (w_we && (rdB_index == rgD_index_in)) begin
            rdB_data = w_wb_data;
        end else if (int'(rdB_index) < NREGS) begin
            rdB_data = r_regs[rdB_index];
        end else begin
            rdB_data = 32'd0;
        end
    end

    // Register file commit; reset clears everything and blocks the edge's write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_we && (int'(rgD_index_in) < NREGS)) begin
            r_regs[rgD_index_in] <= w_wb_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Retired-instruction counter; every valid slot retires, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= {CNT_W{1'b0}};
        end else if (wb_valid) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_retired <= r_retired;
        end
    end

    assign retired_count = r_retired;

endmodule
